// File: rtl/mips_pkg.sv
// Shared types and defaults for the pipeline memory-port arbiter.
package mips_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    // Request/grant vector bit positions.
    localparam int REQ_LD = 0;
    localparam int REQ_DM = 1;
    localparam int REQ_IF = 2;
    localparam int REQ_N  = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        OWN_IF = 2'd1,
        OWN_DM = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant encoder: loader first, then starved fetch, data, fetch.
module arb_prio_sel
    import mips_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic             starved,
    input  arb_state_t       state,
    output logic [REQ_N-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (state)
            RUN: begin
                if (req[REQ_LD]) begin
                    gnt[REQ_LD] = 1'b1;
                end else if (starved && req[REQ_IF]) begin
                    gnt[REQ_IF] = 1'b1;
                end else if (req[REQ_DM]) begin
                    gnt[REQ_DM] = 1'b1;
                end else if (req[REQ_IF]) begin
                    gnt[REQ_IF] = 1'b1;
                end
            end
            // The pipeline is frozen while loading; only the loader may touch memory.
            LOAD:    gnt[REQ_LD] = req[REQ_LD];
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for loader, MEM stage and fetch, with load/drain/restart sequencing.
// Optional ARB_STATS_EN adds grant and stall-cycle counters.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall,
    output logic              pipe_restart,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output arb_state_t        dbgState,
    output logic [3:0]        dbgStarveCnt
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_if_gnt,
    output logic [31:0]       stat_dm_gnt,
    output logic [31:0]       stat_stall_cyc
`endif
);

    // Handshake: a requester holds req/addr/wdata stable until it sees gnt in the
    // same cycle; a granted read returns rvalid/rdata exactly one cycle later.

    arb_state_t        state, stateNext;
    owner_t            respOwner, ownerNext;
    logic [3:0]        starveCnt;
    logic [REQ_N-1:0]  reqVec, gntRaw, gnt;
    logic              starved;
    logic [DATA_W-1:0] ifHold, dmHold;

    assign reqVec  = {if_req, dm_req, ld_req};
    assign starved = (starveCnt == 4'(STARVE_MAX));

    arb_prio_sel uPrioSel (
        .req     (reqVec),
        .starved (starved),
        .state   (state),
        .gnt     (gntRaw)
    );

    // Reset suppresses every combinational output so the reset cycle itself is quiet.
    assign gnt    = rst ? '0 : gntRaw;
    assign ld_gnt = gnt[REQ_LD];
    assign dm_gnt = gnt[REQ_DM];
    assign if_gnt = gnt[REQ_IF];

    assign stall        = ~rst & ((if_req & ~if_gnt) | (dm_req & ~dm_gnt));
    assign pipe_restart = ~rst & (state == DRAIN);

    assign mem_en = |gnt;
    assign mem_we = ld_gnt | (dm_gnt & dm_we);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (dm_gnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        ownerNext = NONE;
        if (if_gnt) begin
            ownerNext = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            ownerNext = OWN_DM;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (ld_gnt) stateNext = LOAD;
            LOAD:    if (!ld_req) stateNext = DRAIN;
            DRAIN:   stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            starveCnt <= 4'd0;
            respOwner <= NONE;
            ifHold    <= '0;
            dmHold    <= '0;
        end else begin
            state     <= stateNext;
            respOwner <= ownerNext;
            if (respOwner == OWN_IF) ifHold <= mem_rdata;
            if (respOwner == OWN_DM) dmHold <= mem_rdata;
            if (state == DRAIN || if_gnt) begin
                starveCnt <= 4'd0;
            end else if (state == RUN && if_req && !starved) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

    // Return data steers straight from the memory; the non-owner keeps its last word.
    assign if_rvalid = ~rst & (respOwner == OWN_IF);
    assign dm_rvalid = ~rst & (respOwner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : ifHold;
    assign dm_rdata  = dm_rvalid ? mem_rdata : dmHold;

    assign dbgState     = state;
    assign dbgStarveCnt = starveCnt;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || pipe_restart) begin
            stat_if_gnt    <= 32'd0;
            stat_dm_gnt    <= 32'd0;
            stat_stall_cyc <= 32'd0;
        end else begin
            stat_if_gnt    <= stat_if_gnt + {31'd0, if_gnt};
            stat_dm_gnt    <= stat_dm_gnt + {31'd0, dm_gnt};
            stat_stall_cyc <= stat_stall_cyc + {31'd0, stall};
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 128x32 memory behind it.
module tb_mem_port_arbiter;
    import mips_pkg::*;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    // Event record: gnt{if,dm,ld}, stall, restart, we, dm_rv, if_rv, state, starve, addr, data
    localparam int EW = 53;
    localparam logic [2:0] G_NO = 3'b000;
    localparam logic [2:0] G_LD = 3'b001;
    localparam logic [2:0] G_DM = 3'b010;
    localparam logic [2:0] G_IF = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, if_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0, dm_addr = '0, if_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0, dm_wdata = '0;
    logic ld_gnt, dm_gnt, dm_rvalid, if_gnt, if_rvalid, stall, pipe_restart, mem_en, mem_we;
    logic [DATA_W-1:0] dm_rdata, if_rdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    arb_state_t dbgState;
    logic [3:0] dbgStarveCnt;
`ifdef ARB_STATS_EN
    logic [31:0] stat_if_gnt, stat_dm_gnt, stat_stall_cyc;
`endif

    logic [DATA_W-1:0] mem [0:127];
    logic [EW-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .stall(stall), .pipe_restart(pipe_restart),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbgState(dbgState), .dbgStarveCnt(dbgStarveCnt)
`ifdef ARB_STATS_EN
        , .stat_if_gnt(stat_if_gnt), .stat_dm_gnt(stat_dm_gnt), .stat_stall_cyc(stat_stall_cyc)
`endif
    );

    // Memory model: one-cycle registered read, write on strobe.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    function automatic logic [EW-1:0] ev(input logic [2:0] g, input logic st, input logic rs,
                                         input logic we, input logic dmrv, input logic ifrv,
                                         input logic [1:0] s, input logic [3:0] sc,
                                         input logic [6:0] a, input logic [31:0] d);
        return {g, st, rs, we, dmrv, ifrv, s, sc, a, d};
    endfunction

    // Monitor: every cycle with a grant, a read return or a restart pulse is one event.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] act, expv;
        if (ld_gnt || dm_gnt || if_gnt || dm_rvalid || if_rvalid || pipe_restart) begin
            act = ev({if_gnt, dm_gnt, ld_gnt}, stall, pipe_restart, mem_we, dm_rvalid, if_rvalid,
                     dbgState, dbgStarveCnt, mem_en ? mem_addr : 7'd0,
                     dm_rvalid ? dm_rdata : (if_rvalid ? if_rdata : (mem_we ? mem_wdata : 32'd0)));
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event t=%0t actual=%h required=none", $time, act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    miscompares++;
                    $display("FAIL event t=%0t actual=%h required=%h", $time, act, expv);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_ld_gnt", {31'd0, ld_gnt}, 32'd0);
        check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pipe_restart", {31'd0, pipe_restart}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_state", {30'd0, dbgState}, {30'd0, RUN});
        check("rst_starve", {28'd0, dbgStarveCnt}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs();
        tick();

        // Load burst: addrs 0..3 = 0x11..0x14, then drain with restart pulse.
        for (int i = 0; i < 4; i++) begin
            ld_req   = 1'b1;
            ld_addr  = 7'(i);
            ld_wdata = 32'h11 + 32'(i);
            exp_q.push_back(ev(G_LD, 0, 0, 1, 0, 0, (i == 0) ? RUN : LOAD, 4'd0, 7'(i), 32'h11 + 32'(i)));
            tick();
        end
        ld_req = 1'b0;
        tick();
        exp_q.push_back(ev(G_NO, 0, 1, 0, 0, 0, DRAIN, 4'd0, 7'd0, 32'd0));
        tick();

        // Lone fetch of addr 2.
        if_req  = 1'b1;
        if_addr = 7'd2;
        exp_q.push_back(ev(G_IF, 0, 0, 0, 0, 0, RUN, 4'd0, 7'd2, 32'd0));
        tick();
        if_req = 1'b0;
        exp_q.push_back(ev(G_NO, 0, 0, 0, 0, 1, RUN, 4'd0, 7'd0, 32'h13));
        tick();

        // Continuous data reads starve fetch until starve count reaches the limit.
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 7'd1;
        if_req  = 1'b1;
        if_addr = 7'd3;
        exp_q.push_back(ev(G_DM, 1, 0, 0, 0, 0, RUN, 4'd0, 7'd1, 32'd0));
        tick();
        for (int k = 1; k < 4; k++) begin
            exp_q.push_back(ev(G_DM, 1, 0, 0, 1, 0, RUN, 4'(k), 7'd1, 32'h12));
            tick();
        end
        exp_q.push_back(ev(G_IF, 1, 0, 0, 1, 0, RUN, 4'd4, 7'd3, 32'h12));
        tick();
        if_req = 1'b0;
        exp_q.push_back(ev(G_DM, 0, 0, 0, 0, 1, RUN, 4'd0, 7'd1, 32'h14));
        tick();
        dm_req = 1'b0;
        exp_q.push_back(ev(G_NO, 0, 0, 0, 1, 0, RUN, 4'd0, 7'd0, 32'h12));
        tick();

        // Data write then read of addr 5.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 7'd5;
        dm_wdata = 32'hDEAD;
        exp_q.push_back(ev(G_DM, 0, 0, 1, 0, 0, RUN, 4'd0, 7'd5, 32'hDEAD));
        tick();
        dm_we = 1'b0;
        exp_q.push_back(ev(G_DM, 0, 0, 0, 0, 0, RUN, 4'd0, 7'd5, 32'd0));
        tick();
        dm_req = 1'b0;
        exp_q.push_back(ev(G_NO, 0, 0, 0, 1, 0, RUN, 4'd0, 7'd0, 32'hDEAD));
        tick();

        // Loader arrives while a fetch read is outstanding.
        if_req  = 1'b1;
        if_addr = 7'd0;
        exp_q.push_back(ev(G_IF, 0, 0, 0, 0, 0, RUN, 4'd0, 7'd0, 32'd0));
        tick();
        if_req   = 1'b0;
        ld_req   = 1'b1;
        ld_addr  = 7'd20;
        ld_wdata = 32'h77;
        exp_q.push_back(ev(G_LD, 0, 0, 1, 0, 1, RUN, 4'd0, 7'd20, 32'h11));
        tick();
        ld_req = 1'b0;
        tick();
        exp_q.push_back(ev(G_NO, 0, 1, 0, 0, 0, DRAIN, 4'd0, 7'd0, 32'd0));
        tick();

        // All three request together: loader wins, others stall through LOAD.
        ld_req   = 1'b1;
        ld_addr  = 7'd21;
        ld_wdata = 32'h55;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 7'd1;
        if_req   = 1'b1;
        if_addr  = 7'd0;
        exp_q.push_back(ev(G_LD, 1, 0, 1, 0, 0, RUN, 4'd0, 7'd21, 32'h55));
        tick();
        ld_addr  = 7'd22;
        ld_wdata = 32'h66;
        exp_q.push_back(ev(G_LD, 1, 0, 1, 0, 0, LOAD, 4'd1, 7'd22, 32'h66));
        tick();
        ld_req = 1'b0;
        dm_req = 1'b0;
        if_req = 1'b0;
        tick();
        exp_q.push_back(ev(G_NO, 0, 1, 0, 0, 0, DRAIN, 4'd1, 7'd0, 32'd0));
        tick();

        // Reset one cycle after a granted fetch: the read never returns.
        if_req  = 1'b1;
        if_addr = 7'd3;
        exp_q.push_back(ev(G_IF, 0, 0, 0, 0, 0, RUN, 4'd0, 7'd3, 32'd0));
        tick();
        if_req = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs();
        tick();

        // Reset in the middle of a load burst: back to RUN with no restart pulse.
        ld_req   = 1'b1;
        ld_addr  = 7'd30;
        ld_wdata = 32'h99;
        exp_q.push_back(ev(G_LD, 0, 0, 1, 0, 0, RUN, 4'd0, 7'd30, 32'h99));
        tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        ld_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("load_rst_state", {30'd0, dbgState}, {30'd0, RUN});
        check("load_rst_restart", {31'd0, pipe_restart}, 32'd0);
        tick();
        tick();

        while (exp_q.size() != 0) begin
            logic [EW-1:0] missing;
            missing = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_event actual=none required=%h", missing);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
